// File: rtl/spi_flash_reader.sv
// SPI mode-0 serial flash read initiator: READ command + 24-bit address, bytes streamed out on valid/ready.
// Optional build macro SPI_FLASH_FAST_READ_EN selects FAST READ (0x0B) with 8 dummy clocks.
module spi_flash_reader #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned CSB_HIGH = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [15:0] req_len,
    output logic [7:0]  data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        busy,
    output logic        done,
    output logic        spi_csb,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CSB_W = (CSB_HIGH > 1) ? $clog2(CSB_HIGH) : 1;
`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0]  READ_CMD = 8'h0B;
    localparam int unsigned TX_W     = 40;
`else
    localparam logic [7:0]  READ_CMD = 8'h03;
    localparam int unsigned TX_W     = 32;
`endif
    localparam int unsigned PAD_W = TX_W - 31;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
`ifdef SPI_FLASH_FAST_READ_EN
        S_DUMMY,
`endif
        S_DATA,
        S_STALL,
        S_END
    } state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              sck_q, sck_d;
    logic              sck_rose_q, sck_rose_d;
    logic              csb_q, csb_d;
    logic              mosi_q, mosi_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [TX_W-1:0]   tx_q, tx_d;
    logic [7:0]        rx_q, rx_d;
    logic [15:0]       rem_q, rem_d;
    logic [CSB_W-1:0]  csbh_q, csbh_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              req_ready_q, req_ready_d;

    logic              tick;
    logic              out_free;
    logic [7:0]        rx_byte;
    logic [4:0]        phase_bits;
    state_e            phase_next;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        sck_d       = sck_q;
        csb_d       = csb_q;
        mosi_d      = mosi_q;
        bit_cnt_d   = bit_cnt_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rem_d       = rem_q;
        csbh_d      = csbh_q;
        data_d      = data_q;
        valid_d     = valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        phase_bits  = 5'd8;
        phase_next  = S_ADDR;
        tick        = (div_q == DIV_W'(CLK_DIV - 1));
        out_free    = !valid_q || data_ready;
        rx_byte     = {rx_q[6:0], spi_miso};

        // consumer handshake frees the output register
        if (valid_q && data_ready) valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    busy_d = 1'b1;
                    rem_d  = req_len;
                    if (req_len == 16'd0) begin
                        state_d = S_END;
                        csbh_d  = CSB_W'(CSB_HIGH - 1);
                    end else begin
                        state_d   = S_CMD;
                        csb_d     = 1'b0;
                        sck_d     = 1'b0;
                        mosi_d    = READ_CMD[7];
                        tx_d      = {READ_CMD[6:0], req_addr, {PAD_W{1'b0}}};
                        div_d     = '0;
                        bit_cnt_d = 5'd0;
                    end
                end
            end

`ifdef SPI_FLASH_FAST_READ_EN
            S_CMD, S_ADDR, S_DUMMY: begin
`else
            S_CMD, S_ADDR: begin
`endif
                case (state_q)
                    S_CMD: begin
                        phase_bits = 5'd8;
                        phase_next = S_ADDR;
                    end
                    S_ADDR: begin
                        phase_bits = 5'd24;
`ifdef SPI_FLASH_FAST_READ_EN
                        phase_next = S_DUMMY;
`else
                        phase_next = S_DATA;
`endif
                    end
                    default: begin
                        phase_bits = 5'd8;
                        phase_next = S_DATA;
                    end
                endcase
                div_d = tick ? '0 : DIV_W'(div_q + DIV_W'(1));
                if (tick) begin
                    if (!sck_q) begin
                        sck_d     = 1'b1;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end else begin
                        // next bit goes out on the falling edge
                        sck_d  = 1'b0;
                        mosi_d = tx_q[TX_W-1];
                        tx_d   = {tx_q[TX_W-2:0], 1'b0};
                        if (bit_cnt_q == phase_bits) begin
                            bit_cnt_d = 5'd0;
                            state_d   = phase_next;
                        end
                    end
                end
            end

            S_DATA: begin
                if (sck_rose_q) begin
                    rx_d = rx_byte;
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d = 5'd0;
                        rem_d     = rem_q - 16'd1;
                        if (out_free) begin
                            data_d  = rx_byte;
                            valid_d = 1'b1;
                        end else begin
                            state_d = S_STALL;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                div_d = tick ? '0 : DIV_W'(div_q + DIV_W'(1));
                if (tick) begin
                    if (sck_q) begin
                        sck_d = 1'b0;
                    end else if (rem_q == 16'd0) begin
                        csb_d   = 1'b1;
                        csbh_d  = '0;
                        state_d = S_END;
                    end else begin
                        sck_d = 1'b1;
                    end
                end
            end

            S_STALL: begin
                // finish the current high phase, then park SCK low
                if (sck_q) begin
                    div_d = tick ? '0 : DIV_W'(div_q + DIV_W'(1));
                    if (tick) sck_d = 1'b0;
                end else begin
                    div_d = '0;
                end
                if (valid_q && data_ready) begin
                    data_d  = rx_q;
                    valid_d = 1'b1;
                    state_d = S_DATA;
                end
            end

            S_END: begin
                if (csbh_q != CSB_W'(CSB_HIGH - 1)) begin
                    csbh_d = CSB_W'(csbh_q + CSB_W'(1));
                end else if (out_free) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        sck_rose_d  = sck_d && !sck_q;
        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            sck_q       <= 1'b0;
            sck_rose_q  <= 1'b0;
            csb_q       <= 1'b1;
            mosi_q      <= 1'b0;
            bit_cnt_q   <= 5'd0;
            tx_q        <= '0;
            rx_q        <= 8'd0;
            rem_q       <= 16'd0;
            csbh_q      <= '0;
            data_q      <= 8'd0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            sck_q       <= sck_d;
            sck_rose_q  <= sck_rose_d;
            csb_q       <= csb_d;
            mosi_q      <= mosi_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rem_q       <= rem_d;
            csbh_q      <= csbh_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign spi_csb    = csb_q;
    assign spi_sck    = sck_q;
    assign spi_mosi   = mosi_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: behavioural mode-0 flash model, table of read transactions,
// plus hand-written zero-length and reset-mid-transfer sequences.
module tb_spi_flash_reader;
`ifdef SPI_FLASH_FAST_READ_EN
    localparam int         HDR     = 40;
    localparam logic [7:0] EXP_CMD = 8'h0B;
`else
    localparam int         HDR     = 32;
    localparam logic [7:0] EXP_CMD = 8'h03;
`endif

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [23:0] req_addr = 24'd0;
    logic [15:0] req_len = 16'd0;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        data_ready = 1'b1;
    logic        busy;
    logic        done;
    logic        spi_csb;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    spi_flash_reader #(.CLK_DIV(2), .CSB_HIGH(4)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy),
        .done       (done),
        .spi_csb    (spi_csb),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] got_v, input logic [63:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got_v, exp_v);
        end
    endtask

    // flash model
    logic [7:0]  mem [0:1023];
    int          rise_cnt = 0;
    int          total_rises = 0;
    int          dummy_bad = 0;
    int          csb_falls = 0;
    int          cyc = 0;
    int          csb_fall_cyc = 0;
    int          first_rise_cyc = 0;
    logic [31:0] hdr_word = 32'd0;
    int          fk;
    int          fidx;
    logic [7:0]  fb;

    always @(posedge wb_clk_i) cyc++;

    always @(posedge spi_sck) begin
        if (spi_csb === 1'b0) begin
            if (rise_cnt == 0) first_rise_cyc = cyc;
            if (rise_cnt < 32) hdr_word = {hdr_word[30:0], spi_mosi};
            else if (rise_cnt < HDR && spi_mosi !== 1'b0) dummy_bad++;
            rise_cnt++;
        end
        total_rises++;
    end

    always @(negedge spi_sck) begin
        if (spi_csb === 1'b0 && rise_cnt >= HDR) begin
            fk       = rise_cnt - HDR;
            fidx     = (int'(hdr_word[23:0]) + fk / 8) % 1024;
            fb       = mem[fidx];
            spi_miso = fb[7 - (fk % 8)];
        end
    end

    always @(posedge spi_csb) rise_cnt = 0;
    always @(negedge spi_csb) begin
        csb_falls++;
        csb_fall_cyc = cyc;
    end

    // output monitor, sampled mid-cycle
    logic [7:0] got_q [$];
    int         done_cnt = 0;
    int         sck_edges = 0;
    logic       sck_prev = 1'b0;

    always @(negedge wb_clk_i) begin
        if (!wb_rst_i && data_valid && data_ready) got_q.push_back(data_out);
        if (done === 1'b1) done_cnt++;
        if (spi_sck !== sck_prev) sck_edges++;
        sck_prev = spi_sck;
    end

    typedef struct {
        logic [23:0] addr;
        logic [15:0] len;
        int          stall;
        logic [31:0] exp_bytes;
        int          data_rises;
    } vec_t;

    vec_t vecs [4];

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int   rises0;
        int   edges0;
        bit   ok;
        logic [7:0] expb;
        string tag;
        tag = $sformatf("v%0d", idx);
        got_q.delete();
        done_cnt  = 0;
        dummy_bad = 0;
        edges0    = 0;
        rises0    = total_rises;
        data_ready = (v.stall == 0);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (req_ready === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
        check({tag, "_req_ready_wait"}, 64'(ok), 64'd1);
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_len   = v.len;
        tick();
        check({tag, "_busy_after_accept"}, 64'({busy, req_ready}), 64'b10);
        // requests while busy must be ignored
        req_addr = 24'hABCDEF;
        req_len  = 16'd7;
        repeat (3) tick();
        req_valid = 1'b0;
        if (v.stall != 0) begin
            ok = 1'b0;
            for (int i = 0; i < 2000; i++) begin
                if (data_valid === 1'b1) begin ok = 1'b1; break; end
                tick();
            end
            check({tag, "_first_byte_wait"}, 64'(ok), 64'd1);
            for (int i = 0; i < v.stall; i++) begin
                if (i == 60) edges0 = sck_edges;
                tick();
            end
            check({tag, "_stall_sck_edges"}, 64'(sck_edges - edges0), 64'd0);
            check({tag, "_stall_sck_csb"}, 64'({spi_sck, spi_csb}), 64'b00);
            data_ready = 1'b1;
        end
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (done_cnt > 0) begin ok = 1'b1; break; end
            tick();
        end
        check({tag, "_done_wait"}, 64'(ok), 64'd1);
        repeat (3) tick();
        check({tag, "_cmd_addr"}, 64'(hdr_word), 64'({EXP_CMD, v.addr}));
        check({tag, "_byte_count"}, 64'(got_q.size()), 64'(v.len));
        for (int i = 0; i < int'(v.len); i++) begin
            expb = v.exp_bytes[31 - 8*i -: 8];
            if (i < got_q.size()) check($sformatf("%s_byte%0d", tag, i), 64'(got_q[i]), 64'(expb));
        end
        check({tag, "_sck_rises"}, 64'(total_rises - rises0), 64'(HDR + v.data_rises));
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, "_dummy_mosi"}, 64'(dummy_bad), 64'd0);
        check({tag, "_first_rise_lat"}, 64'(first_rise_cyc - csb_fall_cyc), 64'd2);
        check({tag, "_idle_state"}, 64'({spi_csb, spi_sck, busy, data_valid, req_ready}), 64'b10001);
    endtask

    int r0;
    int f0;
    bit ok_m;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[0]   = 8'h5A;
        mem[256] = 8'hDE;
        mem[257] = 8'hAD;
        mem[258] = 8'hBE;
        mem[259] = 8'hEF;
        mem[512] = 8'h12;
        mem[513] = 8'h34;

        vecs[0] = '{addr: 24'h000100, len: 16'd4, stall: 0,   exp_bytes: 32'hDEADBEEF, data_rises: 32};
        vecs[1] = '{addr: 24'h000100, len: 16'd4, stall: 100, exp_bytes: 32'hDEADBEEF, data_rises: 32};
        vecs[2] = '{addr: 24'h000000, len: 16'd1, stall: 0,   exp_bytes: 32'h5A000000, data_rises: 8};
        vecs[3] = '{addr: 24'h000200, len: 16'd2, stall: 0,   exp_bytes: 32'h12340000, data_rises: 16};

        // reset held for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("reset_cycle%0d", i),
                  64'({spi_csb, spi_sck, data_valid, busy, req_ready}), 64'b10001);
        end
        check("reset_outputs", 64'({data_out, done, spi_mosi}), 64'd0);
        wb_rst_i = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) run_txn(vecs[i], i);

        // zero-length request: done next cycle, no chip select, no clocks
        r0 = total_rises;
        f0 = csb_falls;
        done_cnt = 0;
        req_valid = 1'b1;
        req_addr  = 24'h000100;
        req_len   = 16'd0;
        tick();
        req_valid = 1'b0;
        check("zl_accept", 64'({busy, done, req_ready, spi_csb}), 64'b1001);
        tick();
        check("zl_done", 64'({busy, done, req_ready, spi_csb}), 64'b0111);
        tick();
        check("zl_after", 64'({done, req_ready}), 64'b01);
        check("zl_no_sck", 64'(total_rises - r0), 64'd0);
        check("zl_no_csb", 64'(csb_falls - f0), 64'd0);
        check("zl_done_count", 64'(done_cnt), 64'd1);

        // reset during the second data byte
        got_q.delete();
        data_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 24'h000100;
        req_len   = 16'd4;
        tick();
        req_valid = 1'b0;
        ok_m = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (got_q.size() >= 1) begin ok_m = 1'b1; break; end
            tick();
        end
        check("rst_mid_first_byte", 64'(ok_m), 64'd1);
        repeat (10) tick();
        check("rst_mid_active", 64'({spi_csb, busy}), 64'b01);
        wb_rst_i = 1'b1;
        tick();
        check("rst_mid_outputs", 64'({spi_csb, spi_sck, data_valid, busy, req_ready}), 64'b10001);
        wb_rst_i = 1'b0;
        tick();
        run_txn(vecs[2], 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/spi_flash_reader.md
# spi_flash_reader

SPI-mode-0 flash read initiator for the user project area; it is the controller side of the serial flash link that the testbench flash model (csb/clk/io0/io1) answers. It accepts a byte address and length, issues a READ command with a 24-bit address, and streams the returned bytes out on a valid/ready port with backpressure. It gives user logic direct access to a dedicated external flash, wired through mprj_io pads, without going through the management SoC.

## Interface
- CLK_DIV, 2: SCK half-period in wb_clk_i cycles; legal range ≥1.
- CSB_HIGH, 4: minimum number of wb_clk_i cycles spi_csb stays high after a transaction.
- wb_clk_i  input  1  system clock; all logic is on the rising edge.
- wb_rst_i  input  1  reset, synchronous and active-high.
- req_valid  input  1  request strobe.
- req_ready  output  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_addr  input  24  start byte address, captured on accept.
- req_len  input  16  byte count, captured on accept; 0 is legal.
- data_out  output  8  received byte.
- data_valid  output  1  data_out holds a byte.
- data_ready  input  1  consumer accepts the byte when data_valid && data_ready.
- busy  output  1  high from accept until done.
- done  output  1  one-cycle pulse at the end of a transaction.
- spi_csb  output  1  chip select, active-low.
- spi_sck  output  1  serial clock; idles low.
- spi_mosi  output  1  serial data out, MSB first.
- spi_miso  input  1  serial data in, sampled on the SCK rising edge.

## Operation
- Reset values: spi_csb=1, spi_sck=0, spi_mosi=0, data_out=0, data_valid=0, busy=0, done=0, req_ready=1. The FSM goes to IDLE and the length counter clears.
- FSM states: IDLE → CMD (8 bits) → ADDR (24 bits) → [DUMMY (8 bits), only with the macro] → DATA → STALL ↔ DATA → END → IDLE.
- IDLE, on accept with req_len=0: go straight to END. spi_csb never falls, and done pulses on the next cycle.
- IDLE, on accept with req_len≠0: drive spi_csb low and spi_mosi to command bit 7. The command is 0x03.
- CMD, ADDR, DUMMY: shift MSB first. spi_mosi changes only while spi_sck is low. During DUMMY, spi_mosi is 0.
- DATA: shift spi_miso into an 8-bit shift register on each SCK rise. After the 8th bit, move the byte into data_out, set data_valid and decrement the remaining count.
- Backpressure:
  - If data_valid is still set when a new byte completes, go to STALL. SCK is held low and the shift register holds the byte.
  - On a consumer handshake, load the held byte into data_out and resume SCK one half-period later.
  - No byte is ever dropped or duplicated.
- Last byte: after the final SCK rise, wait one half-period with SCK low, then set spi_csb=1 and enter END.
- END: hold spi_csb high for CSB_HIGH cycles and wait for the last byte's handshake. Then pulse done, clear busy and return to IDLE.
- Address wraps at 0xFFFFFF; this is the flash's responsibility, and the block adds no checks.
- wb_rst_i asserted mid-transaction: all outputs take their reset values on the next clock edge, including spi_csb=1 and data_valid=0. The pending byte is discarded.

## Timing
- SCK period = 2·CLK_DIV cycles. First SCK rise is CLK_DIV cycles after spi_csb falls.
- Clock-edge budget without stalls: 32 edges of command and address, plus 8 with the macro, plus 8·req_len data edges.
- A byte reaches data_valid 1 cycle after its 8th SCK rise.
- Throughput: one byte per 16·CLK_DIV cycles when data_ready is held high.
- req_ready=0 whenever busy=1; requests made while busy are ignored.

## Configuration
- SPI_FLASH_FAST_READ_EN
  - Defined: command 0x0B, followed by the DUMMY state (8 SCK cycles) between ADDR and DATA.
  - Undefined: command 0x03 and no DUMMY state; the DUMMY logic is not synthesized.

## Test plan
- Reset: hold wb_rst_i 5 cycles → spi_csb=1, spi_sck=0, data_valid=0, busy=0 and req_ready=1 on every cycle.
- Basic read:
  - Stimulus: flash model preloaded with 0xDE 0xAD 0xBE 0xEF at 0x000100; request addr=0x000100, len=4, CLK_DIV=2, data_ready=1.
  - Response: MOSI bits 0x03 0x00 0x01 0x00; bytes DE AD BE EF in order; exactly 64 SCK rises; one done pulse.
- Backpressure: same read with data_ready=0 for 100 cycles after the first byte → SCK stays low during the stall, no SCK edges, all 4 bytes correct, spi_csb stays low until the last byte is shifted in.
- Zero length: len=0 → done one cycle after accept, spi_csb stays 1 and no SCK edge occurs.
- Reset mid-transfer: assert wb_rst_i during the 2nd data byte → spi_csb=1 and data_valid=0 on the next edge. A following read of addr=0, len=1 returns the correct byte.
- With SPI_FLASH_FAST_READ_EN defined: command 0x0B, then 8 dummy SCK cycles with MOSI=0, then the same 4 bytes, for 72 SCK rises in total.
